// File: rtl/vend_payment_fsm.sv
// Payment and dispense controller: latches a one-hot drink selection and its cost, accumulates coin credit,
// then pulses dispense with change or a refund. Optional COLLECT inactivity timeout under `VEND_TIMEOUT_EN`.

module vend_payment_fsm_chk #(
  parameter int CREDIT_W = 4
) (
  input logic                clk,
  input logic                rst,
  input logic [CREDIT_W-1:0] credit,
  input logic                dispense,
  input logic                refund,
  input logic                change_valid
);

  // The largest pre-coin credit is one below the maximum cost, plus the largest coin.
  a_credit_max: assert property (@(posedge clk) disable iff (!rst)
    credit <= CREDIT_W'(4'd11));

  a_disp_refund_excl: assert property (@(posedge clk) disable iff (!rst)
    !(dispense && refund));

  a_change_with_event: assert property (@(posedge clk) disable iff (!rst)
    change_valid == (dispense || refund));

endmodule

module vend_payment_fsm #(
  parameter int COST_W         = 3,
  parameter int CREDIT_W       = 4,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          sel,
  input  logic [COST_W-1:0]   cost,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic [3:0]          drink,
  output logic [CREDIT_W-1:0] change,
  output logic                change_valid,
  output logic                refund,
  output logic                coin_reject,
  output logic                busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_REFUND   = 2'd3
  } state_e;

  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
    logic [CREDIT_W-1:0] val;
    case (code)
      2'b01:   val = CREDIT_W'(3'd1);
      2'b10:   val = CREDIT_W'(3'd2);
      2'b11:   val = CREDIT_W'(3'd5);
      default: val = CREDIT_W'(3'd0);
    endcase
    return val;
  endfunction

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [3:0]          sel_lat_q, sel_lat_d;
  logic [COST_W-1:0]   cost_lat_q, cost_lat_d;

  logic                dispense_q, dispense_d;
  logic [3:0]          drink_q, drink_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                change_valid_q, change_valid_d;
  logic                refund_q, refund_d;
  logic                coin_reject_q, coin_reject_d;
  logic                busy_q, busy_d;

  logic [CREDIT_W-1:0] coin_amt;
  logic [CREDIT_W-1:0] credit_sum;
  logic [CREDIT_W-1:0] cost_ext;
  logic                coin_accept;
  logic                paid_full;
  logic                timeout_hit;

  assign coin_amt    = coin_valid ? coin_value(coin_code) : '0;
  assign coin_accept = coin_valid && (coin_code != 2'b00);
  assign credit_sum  = credit_q + coin_amt;
  assign cost_ext    = {{(CREDIT_W-COST_W){1'b0}}, cost_lat_q};
  assign paid_full   = (credit_sum >= cost_ext);

`ifdef VEND_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Inactivity counter: restarts on COLLECT entry and on each accepted coin.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == ST_COLLECT) begin
      if (coin_accept) begin
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1'b1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign timeout_hit = (state_q == ST_COLLECT) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1))
                       && !coin_valid && !cancel;
`else
  assign timeout_hit = 1'b0;
`endif

  // State, datapath and registered-output flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      sel_lat_q      <= '0;
      cost_lat_q     <= '0;
      dispense_q     <= 1'b0;
      drink_q        <= '0;
      change_q       <= '0;
      change_valid_q <= 1'b0;
      refund_q       <= 1'b0;
      coin_reject_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      sel_lat_q      <= sel_lat_d;
      cost_lat_q     <= cost_lat_d;
      dispense_q     <= dispense_d;
      drink_q        <= drink_d;
      change_q       <= change_d;
      change_valid_q <= change_valid_d;
      refund_q       <= refund_d;
      coin_reject_q  <= coin_reject_d;
      busy_q         <= busy_d;
    end
  end

  // Next-state and credit/latch update.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    sel_lat_d  = sel_lat_q;
    cost_lat_d = cost_lat_q;
    case (state_q)
      ST_IDLE: begin
        if (is_one_hot(sel) && (cost != '0)) begin
          sel_lat_d  = sel;
          cost_lat_d = cost;
          state_d    = ST_COLLECT;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        credit_d = credit_sum;
        // Payment completion takes priority over a simultaneous cancel.
        if (paid_full) begin
          state_d = ST_DISPENSE;
        end else if (cancel || timeout_hit) begin
          state_d = ST_REFUND;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_DISPENSE, ST_REFUND: begin
        credit_d = '0;
        state_d  = ST_IDLE;
      end
      default: begin
        credit_d = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Output values for the state being entered, registered at the same edge.
  always_comb begin
    dispense_d     = 1'b0;
    drink_d        = '0;
    change_d       = '0;
    change_valid_d = 1'b0;
    refund_d       = 1'b0;
    busy_d         = (state_d != ST_IDLE);
    coin_reject_d  = coin_valid && !((state_q == ST_COLLECT) && coin_accept);
    case (state_d)
      ST_DISPENSE: begin
        dispense_d     = 1'b1;
        drink_d        = sel_lat_d;
        change_d       = credit_d - cost_ext;
        change_valid_d = 1'b1;
      end
      ST_REFUND: begin
        refund_d       = 1'b1;
        change_d       = credit_d;
        change_valid_d = 1'b1;
      end
      default: begin
        dispense_d     = 1'b0;
        change_valid_d = 1'b0;
      end
    endcase
  end

  assign credit       = credit_q;
  assign dispense     = dispense_q;
  assign drink        = drink_q;
  assign change       = change_q;
  assign change_valid = change_valid_q;
  assign refund       = refund_q;
  assign coin_reject  = coin_reject_q;
  assign busy         = busy_q;

  vend_payment_fsm_chk #(
    .CREDIT_W (CREDIT_W)
  ) u_chk (
    .clk          (clk),
    .rst          (rst),
    .credit       (credit_q),
    .dispense     (dispense_q),
    .refund       (refund_q),
    .change_valid (change_valid_q)
  );

endmodule
